// File: rtl/entry_direction_encoder_if.sv
// Doorway sensor bus: raw beam inputs toward the encoder, change/on_off events toward the counter.
interface entry_direction_encoder_if;
  logic beam_a;
  logic beam_b;
  logic change;
  logic on_off;

  modport master (output beam_a, beam_b, input change, on_off);
  modport slave  (input beam_a, beam_b, output change, on_off);
endinterface

// File: rtl/entry_direction_encoder.sv
// Doorway beam pair -> occupancy change/on_off pulses (sync, debounce, direction FSM).
// Optional SATURATE_GUARD_EN: shadow 8-bit occupancy suppresses events that would wrap the counter.
module beam_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
      deb  <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == deb) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

module entry_direction_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input logic                       clk,
  input logic                       rst,
  entry_direction_encoder_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_A1   = 3'd1;
  localparam logic [2:0] S_A2   = 3'd2;
  localparam logic [2:0] S_A3   = 3'd3;
  localparam logic [2:0] S_B1   = 3'd4;
  localparam logic [2:0] S_B2   = 3'd5;
  localparam logic [2:0] S_B3   = 3'd6;
  localparam logic [2:0] S_CLR  = 3'd7;

  logic [1:0]    raw, deb;
  logic [2:0]    state, nxt;
  logic [TW-1:0] tcnt;
  logic          tmo_hit, done_in, done_out, ok_in, ok_out;
  logic          change_q, on_off_q;

  assign raw = {bus.beam_a, bus.beam_b};

  // bit 1 = beam A, bit 0 = beam B
  for (genvar i = 0; i < 2; i++) begin : g_beam
    beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk (clk),
      .rst (rst),
      .raw (raw[i]),
      .deb (deb[i])
    );
  end

  assign tmo_hit = (state != S_IDLE) && (state != S_CLR) && (tcnt == TW'(TIMEOUT_CYCLES));

  always_comb begin
    nxt      = state;
    done_in  = 1'b0;
    done_out = 1'b0;
    case (state)
      S_IDLE: case (deb)
        2'b10: nxt = S_A1;
        2'b01: nxt = S_B1;
        2'b11: nxt = S_CLR;
        default: ;
      endcase
      S_A1: case (deb)
        2'b11: nxt = S_A2;
        2'b00: nxt = S_IDLE;
        2'b01: nxt = S_CLR;
        default: ;
      endcase
      S_A2: case (deb)
        2'b01: nxt = S_A3;
        2'b10: nxt = S_A1;
        2'b00: nxt = S_CLR;
        default: ;
      endcase
      S_A3: case (deb)
        2'b00: begin nxt = S_IDLE; done_in = 1'b1; end
        2'b11: nxt = S_A2;
        2'b10: nxt = S_CLR;
        default: ;
      endcase
      S_B1: case (deb)
        2'b11: nxt = S_B2;
        2'b00: nxt = S_IDLE;
        2'b10: nxt = S_CLR;
        default: ;
      endcase
      S_B2: case (deb)
        2'b10: nxt = S_B3;
        2'b01: nxt = S_B1;
        2'b00: nxt = S_CLR;
        default: ;
      endcase
      S_B3: case (deb)
        2'b00: begin nxt = S_IDLE; done_out = 1'b1; end
        2'b11: nxt = S_B2;
        2'b01: nxt = S_CLR;
        default: ;
      endcase
      default: if (deb == 2'b00) nxt = S_IDLE;
    endcase
    // a stalled crossing is abandoned, even on the cycle it would have completed
    if (tmo_hit) begin
      nxt      = S_CLR;
      done_in  = 1'b0;
      done_out = 1'b0;
    end
  end

`ifdef SATURATE_GUARD_EN
  logic [7:0] shadow;
  assign ok_in  = (shadow != 8'hFF);
  assign ok_out = (shadow != 8'h00);
  always_ff @(posedge clk) begin
    if (!rst) shadow <= '0;
    else if (done_in && ok_in) shadow <= shadow + 8'd1;
    else if (done_out && ok_out) shadow <= shadow - 8'd1;
  end
`else
  assign ok_in  = 1'b1;
  assign ok_out = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state) tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
      change_q <= (done_in && ok_in) || (done_out && ok_out);
      if (done_in && ok_in) on_off_q <= 1'b1;
      else if (done_out && ok_out) on_off_q <= 1'b0;
    end
  end

  assign bus.change = change_q;
  assign bus.on_off = on_off_q;
endmodule

// File: doc/entry_direction_encoder.md
# entry_direction_encoder

- Converts two raw light-beam inputs at a doorway into the `change`/`on_off` event pair consumed by the occupancy up/down counter.
- Synchronises and debounces each beam, then runs a direction-decoding state machine.
- Emits one single-cycle `change` pulse per completed crossing: `on_off=1` for entry (beam A broken first), `on_off=0` for exit (beam B broken first).
- Sits between the door sensor pins and the counter, in the counter's clock domain.

## Interface

Parameters:

- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles (≥1) before a debounced beam level changes.
- `TIMEOUT_CYCLES`, default 255: maximum cycles (≥1) the FSM may stay in one non-idle state.

Ports:

- `clk` input 1: system clock, rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `beam_a` input 1: raw, asynchronous, 1 = beam broken; outer beam.
- `beam_b` input 1: raw, asynchronous, 1 = beam broken; inner beam.
- `change` output 1: one-cycle pulse, crossing completed.
- `on_off` output 1: direction of last crossing, 1 = entry, 0 = exit; valid while `change`=1, held otherwise.

## Operation

Reset (`rst`=0 at a clock edge):

- `change`=0 and `on_off`=0.
- Sync flops, debounced levels `a`/`b` and debounce counters cleared to 0.
- FSM in IDLE; timeout counter 0.
- Reset mid-sequence discards the sequence; no pulse is emitted.

Input conditioning:

- Each beam passes through a two-flop synchroniser.
- Per beam, a counter increments on every edge where the synchronised level differs from the debounced level, and clears whenever they match.
- The debounced level takes the new value on the edge where the counter would reach `DEBOUNCE_CYCLES`; the counter then clears.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles is never seen by the FSM.

FSM (input {a,b}; transitions not listed hold the current state):

- IDLE: 10→A1; 01→B1; 11→CLR.
- A1: 11→A2; 00→IDLE; 01→CLR.
- A2: 01→A3; 10→A1; 00→CLR.
- A3: 00→IDLE and emit entry; 11→A2; 10→CLR.
- B1/B2/B3: mirror of A1/A2/A3 with a and b swapped. B3 on 00 → IDLE and emit exit.
- CLR: 00→IDLE; no pulse is ever emitted from CLR.
- Timeout: the counter clears on every state change. When it reaches `TIMEOUT_CYCLES` in any state other than IDLE or CLR, the next state is CLR.

Emit:

- `change`<=1 for exactly one cycle; `on_off`<=1 for entry, 0 for exit.
- `on_off` is otherwise unchanged.
- Back-to-back crossings give separate pulses; at least one IDLE cycle separates them.

## Timing

- Edge numbering: the first rising edge sampling a new raw level is edge 0.
- Sync output is updated at edge 1.
- Debounced level updates at edge `DEBOUNCE_CYCLES`+1.
- FSM state and `change` update at edge `DEBOUNCE_CYCLES`+2. With the default of 4, `change` is high during the cycle after edge 6.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration

`SATURATE_GUARD_EN`

- Defined:
  - An 8-bit shadow occupancy register, reset to 0, increments on each emitted entry and decrements on each emitted exit.
  - An entry completing while the shadow count is 255 is suppressed: no pulse, the FSM returns to IDLE, `on_off` is unchanged.
  - An exit completing while the shadow count is 0 is suppressed the same way.
  - This keeps the downstream 8-bit counter from wrapping.
- Undefined: no shadow register; every completed crossing emits a pulse.

## Test plan

- **Entry:** defaults; hold `beam_a`/`beam_b` at 10, 11, 01, 00, 10 cycles each → exactly one `change` pulse with `on_off`=1, high during the cycle after edge 6 counted from the first 00 sample.
- **Exit:** 01, 11, 10, 00 → one pulse with `on_off`=0; `on_off` stays 0 afterwards.
- **Glitch/abort:** a 3-cycle pulse on `beam_a` gives no pulse and the FSM stays IDLE. The sequence 10, 11, 10, 00 (backing out) gives no pulse.
- **Timeout:** `TIMEOUT_CYCLES`=8; hold 10 for 20 cycles → FSM enters CLR. Then 11, 01, 00 → no pulse.
- **Reset mid-sequence:** drive `rst`=0 for 1 cycle while in A3 → `change`=0, `on_off`=0, IDLE. A subsequent 00 gives no pulse.
- **Guard (`SATURATE_GUARD_EN`):** an exit from reset gives no pulse. Then 256 entries → 255 pulses; the 256th is suppressed.
